base_rskid: RTL and testbench
=============================

BASE_RSKID -- requirements
Module: base_rskid

Interface
REQ-001 Parameter: width, default 1, payload width in bits (>=1).
REQ-002 Parameter: dq, default 0, when 1 o_d is forced to all-zero whenever o_v=0.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous active-low reset (asserted when 0).
REQ-005 Port: i_v  input  1  upstream valid.
REQ-006 Port: i_d  input  [0:width-1]  upstream payload.
REQ-007 Port: i_r  output  1  upstream ready; driven directly from a flop, no combinational path from o_r.
REQ-008 Port: o_v  output  1  downstream valid; driven directly from a flop.
REQ-009 Port: o_d  output  [0:width-1]  downstream payload; driven from the main data register.
REQ-010 Port: o_r  input  1  downstream ready.
REQ-011 Port: o_cnt  output  [0:1]  occupancy (0, 1 or 2 entries held).

Function
REQ-012 Transfer rules: an input transfer occurs when i_v=1 and i_r=1 at a clock edge; an output transfer occurs when o_v=1 and o_r=1 at a clock edge.
REQ-013 Storage: the block SHALL hold one main register (drives o_d) and one skid register.
REQ-014 State machine: the block SHALL implement states EMPTY (cnt 0), ONE (cnt 1) and FULL (cnt 2).
REQ-015 Outputs per state: o_v=0 in EMPTY and 1 in ONE/FULL; o_cnt equals the state occupancy.
REQ-016 i_r timing: after reset release, i_r=1 in EMPTY and ONE and i_r=0 in FULL, computed from next-state and registered.
REQ-017 EMPTY transitions: i_v -> ONE with main<=i_d; otherwise stay in EMPTY.
REQ-018 ONE, i_v & o_r: stay in ONE with main<=i_d (simultaneous in/out, no bubble).
REQ-019 ONE, i_v & ~o_r: go to FULL with skid<=i_d; main is held.
REQ-020 ONE, ~i_v & o_r: go to EMPTY.
REQ-021 ONE, ~i_v & ~o_r: hold state and data.
REQ-022 FULL, o_r: go to ONE with main<=skid.
REQ-023 FULL, ~o_r: hold state and data; i_v is ignored in FULL because i_r=0.
REQ-024 Latency: data accepted at edge N SHALL appear on o_v/o_d after edge N; order is strictly FIFO.
REQ-025 Throughput: one transfer per cycle sustained whenever o_r=1 continuously.
REQ-026 Stability: o_d SHALL stay stable while o_v=1 and o_r=0; no data is lost or duplicated.
REQ-027 Zeroing: with dq=1, main is loaded with zeros on any transition into EMPTY, so o_d is all-zero whenever o_v=0.
REQ-028 No zeroing: with dq=0, data registers load only on accepted transfers.
REQ-029 Ignored input: i_v and i_d SHALL be ignored whenever i_r=0, including during reset.

Reset
REQ-030 While reset=0: state=EMPTY, o_v=0, i_r=0, o_cnt=0, main=0, skid=0, all asynchronously.
REQ-031 Ready release: i_r SHALL rise to 1 on the first rising clk edge after reset deasserts; no input transfer is possible on that edge.
REQ-032 Mid-operation reset: reset asserted in any state discards all held entries immediately; no partial transfer completes.

Verification
REQ-033 Reset release: reset 0->1, i_v=1, i_d=0x5 -> i_r=0 before the first edge, 1 after it; o_v=1 with o_d=0x5 one edge after the first accept.
REQ-034 Streaming: o_r=1, i_v=1 for 8 cycles with d=1..8 -> o_d=1..8 on consecutive cycles; o_cnt stays 1; no bubble.
REQ-035 Stall into skid: in ONE with o_d=A, i_v=1 with d=B and o_r=0 -> FULL, i_r=0 next cycle, o_d=A held; o_r=1 -> o_d=B, i_r=1.
REQ-036 Drain: FULL, i_v=0, o_r=1 for 2 cycles -> cnt 2->1->0, o_v=0; with dq=1 o_d=0 after the drain.
REQ-037 Async reset mid-FULL: reset=0 between edges -> o_v=0, i_r=0, o_cnt=0 immediately, without waiting for a clock edge.
REQ-038 Random test: random i_v/o_r with a scoreboard -> FIFO order holds, no loss or duplication, o_d stable under stall, i_r never combinationally dependent on o_r.

Source files
------------

// File: rtl/base_rskid.sv
// Registered-ready skid buffer: one main register driving o_d plus one skid register.
// i_r, o_v and o_cnt all come straight from flops; i_r never depends combinationally on o_r.
module base_rskid #(
    parameter int width = 1,
    parameter bit dq    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    input  logic [0:width-1] i_d,
    output logic             i_r,
    output logic             o_v,
    output logic [0:width-1] o_d,
    input  logic             o_r,
    output logic [0:1]       o_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           state, state_n;
    logic [0:width-1] main, main_n;
    logic [0:width-1] skid, skid_n;
    logic             rdy;
    logic             vld;
    logic [0:1]       cnt, cnt_n;
    logic             in_xfer;

    // Acceptance uses the registered ready, so i_v is ignored while i_r=0.
    assign in_xfer = i_v & rdy;

    always_comb begin
        state_n = state;
        main_n  = main;
        skid_n  = skid;
        unique case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_n = ONE;
                    main_n  = i_d;
                end
            end
            ONE: begin
                unique case ({in_xfer, o_r})
                    2'b11: main_n = i_d;
                    2'b10: begin
                        state_n = FULL;
                        skid_n  = i_d;
                    end
                    2'b01: begin
                        state_n = EMPTY;
                        if (dq) main_n = '0;
                    end
                    default: ;
                endcase
            end
            FULL: begin
                if (o_r) begin
                    state_n = ONE;
                    main_n  = skid;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_comb begin
        unique case (state_n)
            ONE:     cnt_n = 2'd1;
            FULL:    cnt_n = 2'd2;
            default: cnt_n = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            main  <= '0;
            skid  <= '0;
            rdy   <= 1'b0;
            vld   <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            main  <= main_n;
            skid  <= skid_n;
            rdy   <= (state_n != FULL);
            vld   <= (state_n != EMPTY);
            cnt   <= cnt_n;
        end
    end

    assign i_r   = rdy;
    assign o_v   = vld;
    assign o_d   = main;
    assign o_cnt = cnt;

endmodule

// File: tb/tb_base_rskid.sv
// Bench for base_rskid: directed scenarios plus a random phase, with a FIFO scoreboard
// fed by observed input transfers and drained by observed output transfers.
module tb_base_rskid;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         i_v;
    logic [0:W-1] i_d;
    logic         i_r;
    logic         o_v;
    logic [0:W-1] o_d;
    logic         o_r;
    logic [0:1]   o_cnt;

    int checks   = 0;
    int failures = 0;
    int post     = 0;

    logic [W-1:0] sb[$];

    base_rskid #(.width(W), .dq(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
        .i_v  (i_v),
        .i_d  (i_d),
        .i_r  (i_r),
        .o_v  (o_v),
        .o_d  (o_d),
        .o_r  (o_r),
        .o_cnt(o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release; i_r is only expected high after the first one.
    always @(posedge clk or negedge reset) begin
        if (!reset) post <= 0;
        else if (post < 3) post <= post + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; the caller returns just after the next edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
        i_v = v;
        i_d = d;
        o_r = r;
        @(posedge clk);
        #1;
    endtask

    // Monitor: at the falling edge, the values seen are exactly those the next rising edge uses.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_d;
        logic [W-1:0] exp_d;
        prev_stall = 1'b0;
        prev_d     = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                chk("sb_cnt", 32'(o_cnt), 32'(sb.size()));
                chk("sb_ov", 32'(o_v), 32'(sb.size() != 0));
                if (post >= 1) chk("sb_ir", 32'(i_r), 32'(sb.size() != 2));
                if (!o_v) chk("sb_dq_zero", 32'(o_d), 32'd0);
                if (prev_stall) chk("sb_stable", 32'(o_d), 32'(prev_d));
                if (o_v && o_r) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        exp_d = sb.pop_front();
                        chk("sb_data", 32'(o_d), 32'(exp_d));
                    end
                end
                if (i_v && i_r) sb.push_back(i_d);
                prev_stall = o_v && !o_r;
                prev_d     = o_d;
            end
        end
    end

    initial begin
        reset = 1'b0;
        i_v   = 1'b1;
        i_d   = 8'h05;
        o_r   = 1'b0;
        #1;
        chk("rst_ir", 32'(i_r), 32'd0);
        chk("rst_ov", 32'(o_v), 32'd0);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_od", 32'(o_d), 32'd0);

        // Reset release with i_v held high: no accept on the first edge.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rel_ir_pre", 32'(i_r), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ir_post", 32'(i_r), 32'd1);
        chk("rel_ov_post", 32'(o_v), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ov", 32'(o_v), 32'd1);
        chk("rel_od", 32'(o_d), 32'h05);
        chk("rel_cnt", 32'(o_cnt), 32'd1);

        // Streaming with o_r=1: each value appears the cycle after it is sent, cnt stays 1.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 8'(k), 1'b1);
            chk("stream_od", 32'(o_d), 32'(k));
            chk("stream_cnt", 32'(o_cnt), 32'd1);
        end

        // Stall into the skid register: A=8 held, B=0x42 parked.
        cyc(1'b1, 8'h42, 1'b0);
        chk("stall_cnt", 32'(o_cnt), 32'd2);
        chk("stall_ir", 32'(i_r), 32'd0);
        chk("stall_od", 32'(o_d), 32'h08);
        o_r = 1'b1;
        #1;
        chk("ir_no_comb", 32'(i_r), 32'd0);
        o_r = 1'b0;
        cyc(1'b1, 8'h99, 1'b0);
        chk("full_hold_od", 32'(o_d), 32'h08);
        chk("full_hold_cnt", 32'(o_cnt), 32'd2);
        cyc(1'b0, 8'h00, 1'b1);
        chk("unstall_od", 32'(o_d), 32'h42);
        chk("unstall_ir", 32'(i_r), 32'd1);
        chk("unstall_cnt", 32'(o_cnt), 32'd1);

        // Drain from FULL to EMPTY; zeroing must clear o_d.
        cyc(1'b1, 8'h11, 1'b0);
        chk("drain_full", 32'(o_cnt), 32'd2);
        cyc(1'b0, 8'h00, 1'b1);
        chk("drain_cnt1", 32'(o_cnt), 32'd1);
        chk("drain_od1", 32'(o_d), 32'h11);
        cyc(1'b0, 8'h00, 1'b1);
        chk("drain_cnt0", 32'(o_cnt), 32'd0);
        chk("drain_ov", 32'(o_v), 32'd0);
        chk("drain_od0", 32'(o_d), 32'd0);

        // Asynchronous reset while FULL, asserted between edges.
        cyc(1'b1, 8'h21, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        chk("pre_arst_cnt", 32'(o_cnt), 32'd2);
        i_v = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ov", 32'(o_v), 32'd0);
        chk("arst_ir", 32'(i_r), 32'd0);
        chk("arst_cnt", 32'(o_cnt), 32'd0);
        chk("arst_od", 32'(o_d), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Random traffic; the monitor checks order, occupancy, stability and zeroing.
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0 || n % 16 < 4));
        end
        for (int n = 0; n < 5; n++) cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        chk("final_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
